thread_loader: RTL

- Read-side counterpart to the per-thread result memory.
- Accepts a load request (thread, local word address, length), issues 1-cycle-latency reads on the memory's procb read port and streams the words into the owning core.
- Honours per-core backpressure.
- Updates thread state once the last word has been delivered.
- Sits between the process-block scheduler and the cores' input ports.

---
 rtl/thread_loader_pkg.sv | 22 ++
 rtl/thread_loader_if.sv | 41 ++++
 rtl/thread_loader_fifo.sv | 47 ++++
 rtl/thread_loader.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/thread_loader_pkg.sv
// Shared widths, thread-state constants and loader FSM encoding for the
// per-thread result-memory read path.
package thread_loader_pkg;

    localparam int MEM_ADDR_MSB     = 3;
    localparam int THREAD_STATE_MSB = 1;
    localparam int LEN_W            = 4;

    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_BUSY = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

    // Index of the highest set bit (0 for v < 2).
    function automatic int msb_of(input int v);
        return (v < 2) ? 0 : $clog2(v + 1) - 1;
    endfunction

endpackage

// File: rtl/thread_loader_if.sv
// Request, memory read port, core write bus and thread-state update signals
// of the thread loader.
interface thread_loader_if
    import thread_loader_pkg::*;
#(
    parameter int N_CORES = 3
);
    localparam int N_THREADS     = 2 * N_CORES;
    localparam int N_THREADS_MSB = msb_of(N_THREADS - 1);
    localparam int MEM_TOTAL_MSB = N_THREADS_MSB + 1 + MEM_ADDR_MSB;

    logic                        req_valid;
    logic                        req_ready;
    logic [N_THREADS_MSB:0]      req_thread;
    logic [MEM_ADDR_MSB:0]       req_addr;
    logic [LEN_W-1:0]            req_len;
    logic                        mem_rd_en;
    logic [MEM_TOTAL_MSB:0]      mem_rd_addr;
    logic [31:0]                 mem_dout;
    logic [31:0]                 core_dout;
    logic [N_CORES-1:0]          core_wr_en;
    logic                        core_seq;
    logic [N_CORES-1:0]          core_full;
    logic [N_THREADS_MSB:0]      ts_num;
    logic                        ts_wr_en;
    logic [THREAD_STATE_MSB:0]   ts_wr;
    logic                        err;

    modport master (
        input  req_valid, req_thread, req_addr, req_len, mem_dout, core_full,
        output req_ready, mem_rd_en, mem_rd_addr, core_dout, core_wr_en,
               core_seq, ts_num, ts_wr_en, ts_wr, err
    );

    modport slave (
        output req_valid, req_thread, req_addr, req_len, mem_dout, core_full,
        input  req_ready, mem_rd_en, mem_rd_addr, core_dout, core_wr_en,
               core_seq, ts_num, ts_wr_en, ts_wr, err
    );

endinterface

// File: rtl/thread_loader_fifo.sv
// Small register-array FIFO buffering read words between the memory port and
// the core bus; only the pointers are reset.
module loader_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (count == '0);
        full     = (count == (AW+1)'(DEPTH));
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full)  wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop  && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/thread_loader.sv
// Streams a thread's words from the result memory into the owning core,
// honouring per-core backpressure, then marks the thread state.
module thread_loader
    import thread_loader_pkg::*;
#(
    parameter int N_CORES    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic             CLK,
    input logic             RST_N,
    thread_loader_if.master bus
);
    localparam int N_THREADS = 2 * N_CORES;
    localparam int TW        = msb_of(N_THREADS - 1) + 1;
    localparam int AW        = MEM_ADDR_MSB + 1;
    localparam int FCW       = $clog2(FIFO_DEPTH) + 1;

    typedef logic [LEN_W:0] cnt_t;

    ld_state_e        state_q, state_d;
    logic [TW-1:0]    thread_q, thread_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    cnt_t             rd_cnt_q, rd_cnt_d;
    cnt_t             wr_cnt_q, wr_cnt_d;
    logic             inflight_q, inflight_d;
    logic             err_q, err_d;

    logic             rd_en, ts_pulse, deliver, credit_ok;
    logic             fifo_pop, fifo_empty, fifo_full;
    logic [FCW-1:0]   fifo_count;
    logic [31:0]      fifo_head;
    logic [N_CORES-1:0] wr_en;

    // Push is driven by the registered issue strobe, so read data lands one
    // cycle after the address and a reset drops anything still in flight.
    loader_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (inflight_q),
        .din   (bus.mem_dout),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        thread_d   = thread_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        rd_en      = 1'b0;
        ts_pulse   = 1'b0;

        deliver = (state_q != ST_IDLE) && !fifo_empty;
        // Leave one slot for the word already on its way from memory.
        credit_ok = !fifo_full &&
                    ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH - 1);
        for (int c = 0; c < N_CORES; c++)
            wr_en[c] = deliver && (int'(thread_q >> 1) == c) && !bus.core_full[c];
        fifo_pop = |wr_en;
        if (fifo_pop) wr_cnt_d = wr_cnt_q + cnt_t'(1);

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    thread_d = bus.req_thread;
                    addr_d   = bus.req_addr;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    if (int'(bus.req_thread) >= N_THREADS) begin
                        err_d   = 1'b1;
                        len_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        len_d = bus.req_len;
                        if (bus.req_len == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_READ;
                            if (int'(bus.req_addr) + int'(bus.req_len) > (1 << AW))
                                err_d = 1'b1;
                        end
                    end
                end
            end
            ST_READ: begin
                if ((rd_cnt_q < cnt_t'(len_q)) && credit_ok) begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q + cnt_t'(1);
                end
                if (fifo_pop && (wr_cnt_q + cnt_t'(1) == cnt_t'(len_q)))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                ts_pulse = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        inflight_d = rd_en;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            thread_q   <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            thread_q   <= thread_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = {thread_q, addr_q + AW'(rd_cnt_q)};
    assign bus.core_dout   = fifo_empty ? '0 : fifo_head;
    assign bus.core_wr_en  = wr_en;
    assign bus.core_seq    = thread_q[0];
    assign bus.ts_num      = thread_q;
    assign bus.ts_wr_en    = ts_pulse;
    assign bus.ts_wr       = THREAD_STATE_BUSY;
    assign bus.err         = err_q;

endmodule
